// File: rtl/debug_cmd_dispatch_if.sv
// ----------------------------------------------------------------------------
// debug_cmd_dispatch_if
// Purpose : groups the JTAG-side update/shift signals and the dispatch-side
//           command handshake of debug_cmd_dispatch into one bundle.
// Signals :
//   vs_udr, vs_uir  update-DR / update-IR levels from the TCK domain
//   ir_in [IR_W]    JTAG instruction
//   sr    [DR_W]    TCK-side shift register contents
//   cmd_ready       consumer accepts a dispatched command this cycle
//   jdo   [DR_W]    payload of the most recently dispatched command
//   take_action_a / take_action_b / take_no_action [NCH]
//                   one-hot, single-cycle dispatch pulses
// Modports: master = JTAG/consumer side, slave = the dispatcher.
// ----------------------------------------------------------------------------
interface debug_cmd_dispatch_if #(
    parameter int DR_W = 38,
    parameter int IR_W = 2
);
    localparam int NCH = 2 ** IR_W;

    logic            vs_udr;
    logic            vs_uir;
    logic [IR_W-1:0] ir_in;
    logic [DR_W-1:0] sr;
    logic            cmd_ready;
    logic [DR_W-1:0] jdo;
    logic [NCH-1:0]  take_action_a;
    logic [NCH-1:0]  take_action_b;
    logic [NCH-1:0]  take_no_action;

    modport master (
        output vs_udr, vs_uir, ir_in, sr, cmd_ready,
        input  jdo, take_action_a, take_action_b, take_no_action
    );

    modport slave (
        input  vs_udr, vs_uir, ir_in, sr, cmd_ready,
        output jdo, take_action_a, take_action_b, take_no_action
    );
endinterface

// File: rtl/debug_cmd_dispatch.sv
// ----------------------------------------------------------------------------
// debug_cmd_dispatch
// Purpose : brings JTAG update-IR / update-DR events into the clk domain,
//           queues each update-DR as a {ir, sr} command in a small FIFO and
//           dispatches queued commands to the consumer as one-hot pulses.
// Ports   :
//   clk           system clock, all state changes on its rising edge
//   reset         synchronous active-high reset
//   dbg           debug_cmd_dispatch_if.slave (JTAG inputs + dispatch outputs)
//   clr_overflow  clears the sticky overflow flag
//   ir_q          instruction latched on the last update-IR event
//   fifo_count    number of queued commands (0..DEPTH)
//   overflow      sticky, set when a command is dropped on a full FIFO
// ----------------------------------------------------------------------------
module debug_cmd_dispatch #(
    parameter int                      DR_W  = 38,
    parameter int                      IR_W  = 2,
    parameter int                      DEPTH = 4,
    parameter logic [(2**IR_W)-1:0]    CH_EN = '1
) (
    input  logic                     clk,
    input  logic                     reset,
    debug_cmd_dispatch_if.slave      dbg,
    input  logic                     clr_overflow,
    output logic [IR_W-1:0]          ir_q,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);
    localparam int NCH = 2 ** IR_W;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int EW  = IR_W + DR_W;

    // ------------------------------------------------------------------
    // Clock-domain crossing of the update strobes.
    // Bit 0 and bit 1 form the synchronizer, bit 2 is the edge-detect flop.
    // ------------------------------------------------------------------
    logic [2:0] udr_sync_q;
    logic [2:0] uir_sync_q;
    logic       sync_valid_q;   // stage 1 holds a real post-reset sample
    logic       udr_armed_q;    // a low level has been seen since reset
    logic       uir_armed_q;
    logic       udr_ev;
    logic       uir_ev;

    always_ff @(posedge clk) begin
        if (reset) begin
            udr_sync_q   <= '0;
            uir_sync_q   <= '0;
            sync_valid_q <= 1'b0;
            udr_armed_q  <= 1'b0;
            uir_armed_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its neighbours.
            udr_sync_q   <= {udr_sync_q[1:0], dbg.vs_udr};
            uir_sync_q   <= {uir_sync_q[1:0], dbg.vs_uir};
            sync_valid_q <= 1'b1;
            if (sync_valid_q && !udr_sync_q[0]) udr_armed_q <= 1'b1;
            if (sync_valid_q && !uir_sync_q[0]) uir_armed_q <= 1'b1;
        end
    end

    // A level still high from before reset must be seen low before the next
    // rising edge counts, so the zeroed stage 3 cannot fake an edge.
    assign udr_ev = udr_sync_q[1] & ~udr_sync_q[2] & udr_armed_q;
    assign uir_ev = uir_sync_q[1] & ~uir_sync_q[2] & uir_armed_q;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [EW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            overflow_q, overflow_d;

    logic            full;
    logic            pop;
    logic            push;
    logic            drop;
    logic [EW-1:0]   head;
    logic [IR_W-1:0] head_ir;
    logic [DR_W-1:0] head_sr;

    assign full    = (count_q == CW'(DEPTH));
    assign pop     = (count_q != '0) && dbg.cmd_ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO is
    // still accepted; when full, wr_ptr equals rd_ptr and the head is read
    // before the write lands.
    assign push    = udr_ev && (!full || pop);
    assign drop    = udr_ev && full && !pop;
    assign head    = mem_q[rd_ptr_q];
    assign head_ir = head[DR_W +: IR_W];
    assign head_sr = head[DR_W-1:0];

    // ------------------------------------------------------------------
    // Dispatch outputs
    // ------------------------------------------------------------------
    logic [DR_W-1:0] jdo_q,  jdo_d;
    logic [NCH-1:0]  act_a_q, act_a_d;
    logic [NCH-1:0]  act_b_q, act_b_d;
    logic [NCH-1:0]  no_act_q, no_act_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        jdo_d      = jdo_q;
        act_a_d    = '0;
        act_b_d    = '0;
        no_act_d   = '0;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A fresh drop wins over a clear in the same cycle.
        if (drop)              overflow_d = 1'b1;
        else if (clr_overflow) overflow_d = 1'b0;

        if (pop) begin
            jdo_d = head_sr;
            // Disabled channels still consume the entry but stay silent.
            if (CH_EN[head_ir]) begin
                if (!head_sr[DR_W-1])      no_act_d[head_ir] = 1'b1;
                else if (!head_sr[DR_W-2]) act_a_d[head_ir]  = 1'b1;
                else                       act_b_d[head_ir]  = 1'b1;
            end
        end
    end

    // NOTE: the FIFO storage has no reset; emptiness is tracked by count_q
    // and the pointers, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {dbg.ir_in, dbg.sr};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            jdo_q      <= '0;
            act_a_q    <= '0;
            act_b_q    <= '0;
            no_act_q   <= '0;
            ir_q       <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            jdo_q      <= jdo_d;
            act_a_q    <= act_a_d;
            act_b_q    <= act_b_d;
            no_act_q   <= no_act_d;
            if (uir_ev) ir_q <= dbg.ir_in;
        end
    end

    assign dbg.jdo            = jdo_q;
    assign dbg.take_action_a  = act_a_q;
    assign dbg.take_action_b  = act_b_q;
    assign dbg.take_no_action = no_act_q;
    assign fifo_count         = count_q;
    assign overflow           = overflow_q;

endmodule

// File: tb/tb_debug_cmd_dispatch.sv
// ----------------------------------------------------------------------------
// tb_debug_cmd_dispatch
// Directed bench for debug_cmd_dispatch. u_dut uses the default channel mask,
// u_dut_m uses CH_EN = 4'b1101 to exercise a disabled channel.
// Inputs change 1 ns after a rising edge and outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_debug_cmd_dispatch;
    logic clk;
    logic reset;
    logic clr_overflow;
    logic clr_overflow_m;
    logic [1:0] ir_q,   ir_q_m;
    logic [2:0] count,  count_m;
    logic       ovf,    ovf_m;

    int tests_run    = 0;
    int tests_failed = 0;

    debug_cmd_dispatch_if #(.DR_W(38), .IR_W(2)) if_a ();
    debug_cmd_dispatch_if #(.DR_W(38), .IR_W(2)) if_m ();

    debug_cmd_dispatch #(.DR_W(38), .IR_W(2), .DEPTH(4)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .dbg          (if_a),
        .clr_overflow (clr_overflow),
        .ir_q         (ir_q),
        .fifo_count   (count),
        .overflow     (ovf)
    );

    debug_cmd_dispatch #(.DR_W(38), .IR_W(2), .DEPTH(4), .CH_EN(4'b1101)) u_dut_m (
        .clk          (clk),
        .reset        (reset),
        .dbg          (if_m),
        .clr_overflow (clr_overflow_m),
        .ir_q         (ir_q_m),
        .fifo_count   (count_m),
        .overflow     (ovf_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] pulses_a();
        return {if_a.take_action_a, if_a.take_action_b, if_a.take_no_action};
    endfunction

    function automatic logic [11:0] pulses_m();
        return {if_m.take_action_a, if_m.take_action_b, if_m.take_no_action};
    endfunction

    // One update-DR on u_dut, no observation (push lands on the 3rd edge).
    task automatic send_quiet(input logic [1:0] ir, input logic [37:0] sr);
        if_a.ir_in  = ir;
        if_a.sr     = sr;
        if_a.vs_udr = 1'b1;
        tick(); tick();
        if_a.vs_udr = 1'b0;
        tick(); tick(); tick();
    endtask

    // One update-DR on u_dut with cmd_ready=1; expects the pulse exactly on
    // the 4th edge counting the first edge that samples vs_udr=1.
    task automatic send_watch(input logic [1:0] ir, input logic [37:0] sr,
                              input logic [11:0] exp_p, input string name);
        int          lat;
        bit          seen;
        logic [11:0] got_p;
        logic [11:0] next_p;
        logic [37:0] got_j;
        seen   = 0;
        lat    = 0;
        got_p  = '0;
        next_p = '1;
        got_j  = '0;
        if_a.ir_in  = ir;
        if_a.sr     = sr;
        if_a.vs_udr = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 2) if_a.vs_udr = 1'b0;
            if (seen && k == lat + 1) next_p = pulses_a();
            if (!seen && pulses_a() != '0) begin
                seen  = 1;
                lat   = k;
                got_p = pulses_a();
                got_j = if_a.jdo;
            end
        end
        tests_run++;
        if (lat !== 4) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d edges expected 4", name, lat);
        end
        tests_run++;
        if (got_p !== exp_p) begin
            tests_failed++;
            $display("FAIL %s pulses {a,b,n}: got %h expected %h", name, got_p, exp_p);
        end
        tests_run++;
        if (got_j !== sr) begin
            tests_failed++;
            $display("FAIL %s jdo: got %h expected %h", name, got_j, sr);
        end
        tests_run++;
        if (next_p !== 12'h0) begin
            tests_failed++;
            $display("FAIL %s pulse width: next cycle got %h expected 0", name, next_p);
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if ({count, ovf, ir_q} !== 6'h0 || if_a.jdo !== 38'h0 || pulses_a() !== 12'h0) begin
            tests_failed++;
            $display("FAIL reset_state: count=%0d ovf=%b ir_q=%0d jdo=%h pulses=%h expected all 0",
                     count, ovf, ir_q, if_a.jdo, pulses_a());
        end
    endtask

    task automatic test_uir();
        if_a.ir_in  = 2'b01;
        if_a.vs_uir = 1'b1;
        tick(); tick();
        if_a.vs_uir = 1'b0;
        tick(); tick(); tick();
        tests_run++;
        if (ir_q !== 2'd1) begin
            tests_failed++;
            $display("FAIL uir_latch: got %0d expected 1", ir_q);
        end
    endtask

    task automatic test_decode();
        if_a.cmd_ready = 1'b1;
        // bit 37 of 38'h2_0000_00AB is 0, so this one is a no-action command
        send_watch(2'd1, 38'h2_0000_00AB, {4'b0000, 4'b0000, 4'b0010}, "ch1_no_action_2AB");
        send_watch(2'd1, 38'h20_0000_00AB, {4'b0010, 4'b0000, 4'b0000}, "ch1_action_a");
        send_watch(2'd3, 38'h30_1234_5678, {4'b0000, 4'b1000, 4'b0000}, "ch3_action_b");
        send_watch(2'd0, 38'h1F_FFFF_FFFF, {4'b0000, 4'b0000, 4'b0001}, "ch0_no_action");
        tests_run++;
        if (ir_q !== 2'd1) begin
            tests_failed++;
            $display("FAIL ir_q_hold: got %0d expected 1", ir_q);
        end
    endtask

    task automatic test_overflow();
        logic [37:0] p [5];
        for (int i = 0; i < 5; i++) p[i] = {2'b10, 4'h0, 32'hA000_0000 + i};
        if_a.cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_quiet(2'(i), p[i]);
        tests_run++;
        if (count !== 3'd4 || ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_fill: count=%0d ovf=%b expected count=4 ovf=1", count, ovf);
        end
        tests_run++;
        if (if_a.jdo !== 38'h1F_FFFF_FFFF || pulses_a() !== 12'h0) begin
            tests_failed++;
            $display("FAIL hold_not_ready: jdo=%h pulses=%h expected jdo=1fffffffff pulses=0",
                     if_a.jdo, pulses_a());
        end
        if_a.cmd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests_run++;
            if (if_a.jdo !== p[k] || pulses_a() !== {4'(1 << k), 8'h0} || count !== 3'(3 - k)) begin
                tests_failed++;
                $display("FAIL drain_%0d: jdo=%h pulses=%h count=%0d expected jdo=%h pulses=%h count=%0d",
                         k, if_a.jdo, pulses_a(), count, p[k], {4'(1 << k), 8'h0}, 3 - k);
            end
        end
        tick();
        tests_run++;
        if (pulses_a() !== 12'h0 || count !== 3'd0 || if_a.jdo !== p[3]) begin
            tests_failed++;
            $display("FAIL fifth_dropped: pulses=%h count=%0d jdo=%h expected 0 0 %h",
                     pulses_a(), count, if_a.jdo, p[3]);
        end
    endtask

    task automatic test_clr_priority();
        if_a.cmd_ready = 1'b0;
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        tests_run++;
        if (ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_overflow: got %b expected 0", ovf);
        end
        for (int i = 0; i < 4; i++) send_quiet(2'(i), {2'b11, 36'(i + 16)});
        tests_run++;
        if (count !== 3'd4 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_no_drop: count=%0d ovf=%b expected 4 0", count, ovf);
        end
        // Drop on the 3rd edge while clr_overflow is high.
        if_a.ir_in   = 2'd0;
        if_a.sr      = 38'h00_DEAD_BEEF;
        if_a.vs_udr  = 1'b1;
        clr_overflow = 1'b1;
        tick(); tick();
        if_a.vs_udr = 1'b0;
        tick();
        clr_overflow = 1'b0;
        tests_run++;
        if (ovf !== 1'b1 || count !== 3'd4) begin
            tests_failed++;
            $display("FAIL drop_beats_clear: ovf=%b count=%0d expected 1 4", ovf, count);
        end
        tick(); tick();
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        tests_run++;
        if (ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_after_drop: got %b expected 0", ovf);
        end
    endtask

    task automatic test_full_push_pop();
        logic [37:0] r;
        r = 38'h2A_BCDE_F012;
        if_a.ir_in  = 2'd2;
        if_a.sr     = r;
        if_a.vs_udr = 1'b1;
        tick(); tick();
        if_a.vs_udr    = 1'b0;
        if_a.cmd_ready = 1'b1;
        tick();
        if_a.cmd_ready = 1'b0;
        tests_run++;
        if (count !== 3'd4 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_push_pop: count=%0d ovf=%b expected 4 0", count, ovf);
        end
        tests_run++;
        if (if_a.jdo !== {2'b11, 36'd16} || pulses_a() !== {4'b0000, 4'b0001, 4'b0000}) begin
            tests_failed++;
            $display("FAIL full_push_pop_head: jdo=%h pulses=%h expected %h 010",
                     if_a.jdo, pulses_a(), {2'b11, 36'd16});
        end
        tick(); tick();
        if_a.cmd_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        tests_run++;
        if (if_a.jdo !== r || pulses_a() !== {4'b0100, 8'h0} || count !== 3'd0) begin
            tests_failed++;
            $display("FAIL wrap_order: jdo=%h pulses=%h count=%0d expected %h 400 0",
                     if_a.jdo, pulses_a(), count, r);
        end
        tick();
    endtask

    task automatic test_ch_en();
        logic [11:0] any_p;
        if_m.cmd_ready = 1'b0;
        if_m.ir_in     = 2'd1;
        if_m.sr        = 38'h20_0000_0055;
        if_m.vs_udr    = 1'b1;
        tick(); tick();
        if_m.vs_udr = 1'b0;
        tick(); tick(); tick();
        tests_run++;
        if (count_m !== 3'd1) begin
            tests_failed++;
            $display("FAIL ch_en_queued: count=%0d expected 1", count_m);
        end
        if_m.cmd_ready = 1'b1;
        tick();
        any_p = pulses_m();
        tests_run++;
        if (count_m !== 3'd0 || if_m.jdo !== 38'h20_0000_0055) begin
            tests_failed++;
            $display("FAIL ch_en_pop: count=%0d jdo=%h expected 0 2000000055", count_m, if_m.jdo);
        end
        tick(); any_p |= pulses_m();
        tick(); any_p |= pulses_m();
        tests_run++;
        if (any_p !== 12'h0) begin
            tests_failed++;
            $display("FAIL ch_en_silent: pulses=%h expected 0", any_p);
        end
        // An enabled channel on the masked instance still fires.
        if_m.ir_in  = 2'd2;
        if_m.vs_udr = 1'b1;
        tick(); tick();
        if_m.vs_udr = 1'b0;
        tick(); tick();
        tests_run++;
        if (pulses_m() !== {4'b0100, 8'h0}) begin
            tests_failed++;
            $display("FAIL ch_en_enabled: pulses=%h expected 400", pulses_m());
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [11:0] any_p;
        logic [2:0]  max_c;
        if_a.cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_quiet(2'(i), {2'b10, 36'(i + 32)});
        tests_run++;
        if (count !== 3'd3) begin
            tests_failed++;
            $display("FAIL mid_fill: count=%0d expected 3", count);
        end
        reset       = 1'b1;
        if_a.vs_udr = 1'b1;
        tick(); tick();
        tests_run++;
        if (count !== 3'd0 || ir_q !== 2'd0 || if_a.jdo !== 38'h0) begin
            tests_failed++;
            $display("FAIL mid_reset_state: count=%0d ir_q=%0d jdo=%h expected 0 0 0",
                     count, ir_q, if_a.jdo);
        end
        reset          = 1'b0;
        if_a.cmd_ready = 1'b1;
        tick();
        tests_run++;
        if (pulses_a() !== 12'h0 || count !== 3'd0) begin
            tests_failed++;
            $display("FAIL after_reset_cycle: pulses=%h count=%0d expected 0 0", pulses_a(), count);
        end
        any_p = '0;
        max_c = '0;
        for (int k = 0; k < 6; k++) begin
            tick();
            any_p |= pulses_a();
            if (count > max_c) max_c = count;
        end
        tests_run++;
        if (any_p !== 12'h0 || max_c !== 3'd0) begin
            tests_failed++;
            $display("FAIL held_high_no_event: pulses=%h max_count=%0d expected 0 0", any_p, max_c);
        end
        if_a.vs_udr = 1'b0;
        tick(); tick(); tick();
        send_watch(2'd2, 38'h3F_0000_0001, {4'b0000, 4'b0100, 4'b0000}, "after_reset_event");
    endtask

    initial begin
        reset          = 1'b1;
        clr_overflow   = 1'b0;
        clr_overflow_m = 1'b0;
        if_a.vs_udr = 1'b0; if_a.vs_uir = 1'b0; if_a.ir_in = '0; if_a.sr = '0; if_a.cmd_ready = 1'b0;
        if_m.vs_udr = 1'b0; if_m.vs_uir = 1'b0; if_m.ir_in = '0; if_m.sr = '0; if_m.cmd_ready = 1'b0;
        tick(); tick(); tick();
        test_reset();
        reset = 1'b0;
        tick(); tick(); tick();
        test_uir();
        test_decode();
        test_overflow();
        test_clr_priority();
        test_full_push_pop();
        test_ch_en();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
